// File: rtl/simple_dma_read_controller_pkg.sv
// Shared bus widths, opcodes, device IDs and register map for the DMA read controller.
package simple_dma_read_controller_pkg;
    localparam int FSAB_REQ_W  = 3;
    localparam int FSAB_DID_W  = 4;
    localparam int FSAB_ADDR_W = 31;
    localparam int FSAB_LEN_W  = 4;
    localparam int FSAB_DATA_W = 64;
    localparam int FSAB_MASK_W = 8;

    localparam logic [FSAB_REQ_W-1:0] FSAB_READ  = 3'd0;
    localparam logic [FSAB_REQ_W-1:0] FSAB_WRITE = 3'd1;

    localparam int SPAM_DID_W  = 4;
    localparam int SPAM_ADDR_W = 24;
    localparam int SPAM_DATA_W = 32;

    localparam logic [FSAB_DID_W-1:0] FSAB_DID_CPU         = 4'h0;
    localparam logic [FSAB_DID_W-1:0] FSAB_SUBDID_CPU_DMAC = 4'h0;
    localparam logic [SPAM_DID_W-1:0] SPAM_DID_DMAC        = 4'h0;

    localparam logic [FSAB_LEN_W-1:0] DMA_BURST_BEATS = 4'd8;
    localparam int                    DMA_BURST_BYTES = 64;

    localparam logic [3:0] DMA_REG_START  = 4'd0;
    localparam logic [3:0] DMA_REG_LEN    = 4'd1;
    localparam logic [3:0] DMA_REG_CTRL   = 4'd2;
    localparam logic [3:0] DMA_REG_STATUS = 4'd3;

    localparam int DMA_CTRL_STOP_BIT = 0;
    localparam int DMA_CTRL_GO_BIT   = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dma_state_e;
endpackage

// File: rtl/simple_dma_read_controller_fifo.sv
// Synchronous word FIFO with occupancy count and single-cycle flush.
module dma_sync_fifo
    import simple_dma_read_controller_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = FSAB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

// File: rtl/simple_dma_read_controller.sv
// Looping DMA read engine: FSAB 8-beat bursts into a FIFO, one word per consumer request.
module simple_dma_read_controller
    import simple_dma_read_controller_pkg::*;
#(
    parameter logic [FSAB_DID_W-1:0]  FSAB_DID             = FSAB_DID_CPU,
    parameter logic [FSAB_DID_W-1:0]  FSAB_SUBDID          = FSAB_SUBDID_CPU_DMAC,
    parameter logic [SPAM_DID_W-1:0]  SPAM_DID             = SPAM_DID_DMAC,
    parameter logic [SPAM_ADDR_W-1:0] SPAM_ADDRPFX         = 24'h000000,
    parameter logic [SPAM_ADDR_W-1:0] SPAM_ADDRMASK        = 24'h000000,
    parameter int                     FIFO_DEPTH           = 16,
    parameter logic [30:0]            DEFAULT_LEN          = 31'h00000FFF,
    parameter int                     FSAB_INITIAL_CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    output logic                    dmac__fsabo_valid,
    output logic [FSAB_REQ_W-1:0]   dmac__fsabo_mode,
    output logic [FSAB_DID_W-1:0]   dmac__fsabo_did,
    output logic [FSAB_DID_W-1:0]   dmac__fsabo_subdid,
    output logic [FSAB_ADDR_W-1:0]  dmac__fsabo_addr,
    output logic [FSAB_LEN_W-1:0]   dmac__fsabo_len,
    output logic [FSAB_DATA_W-1:0]  dmac__fsabo_data,
    output logic [FSAB_MASK_W-1:0]  dmac__fsabo_mask,
    input  logic                    dmac__fsabo_credit,
    input  logic                    fsabi_valid,
    input  logic [FSAB_DID_W-1:0]   fsabi_did,
    input  logic [FSAB_DID_W-1:0]   fsabi_subdid,
    input  logic [FSAB_DATA_W-1:0]  fsabi_data,
    input  logic                    spamo_valid,
    input  logic                    spamo_r_nw,
    input  logic [SPAM_DID_W-1:0]   spamo_did,
    input  logic [SPAM_ADDR_W-1:0]  spamo_addr,
    input  logic [SPAM_DATA_W-1:0]  spamo_data,
    output logic                    dmac__spami_busy_b,
    output logic [SPAM_DATA_W-1:0]  dmac__spami_data,
    input  logic                    request,
    output logic [FSAB_DATA_W-1:0]  data,
    output logic                    data_ready
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = $clog2(FSAB_INITIAL_CREDITS + 1);
    localparam int TRK_W  = 16;
    localparam int OCC_W  = TRK_W + 1;

    dma_state_e         state_q, state_d;
    logic               running;
    logic [30:0]        start_q, start_d, len_q, len_d, offset_q, offset_d;
    logic [CRED_W-1:0]  credits_q, credits_d;
    logic [TRK_W-1:0]   inflight_q, inflight_d, discard_q, discard_d;
    logic               req_valid_q;
    logic [30:0]        req_addr_q;
    logic               spam_busy_q;
    logic [31:0]        spam_data_q, spam_rdata;
    logic [63:0]        data_q, fifo_rdata;
    logic               data_ready_q;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occupancy;
    logic [31:0]        offset_adv;
    logic               spam_hit, reg_wr, ctrl_go, ctrl_stop;
    logic               issue, beat_match, beat_keep, beat_drop, pop;
    logic [3:0]         reg_idx;
    logic               unused_spam_bits;

    assign unused_spam_bits = spamo_data[31];

    assign reg_idx   = spamo_addr[3:0];
    assign spam_hit  = spamo_valid && (spamo_did == SPAM_DID)
                     && ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);
    assign reg_wr    = spam_hit && !spamo_r_nw;
    assign ctrl_go   = reg_wr && (reg_idx == DMA_REG_CTRL) && spamo_data[DMA_CTRL_GO_BIT];
    assign ctrl_stop = reg_wr && (reg_idx == DMA_REG_CTRL) && spamo_data[DMA_CTRL_STOP_BIT];

    // Run/idle control.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_go)        state_d = ST_RUN;
        else if (ctrl_stop) state_d = ST_IDLE;
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Reserve FIFO room for whole bursts before asking, so responses can never overflow.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) + OCC_W'(DMA_BURST_BEATS);
    assign issue     = running && (credits_q != '0)
                     && (occupancy <= OCC_W'(FIFO_DEPTH)) && !req_valid_q;

    assign beat_match = fsabi_valid && (fsabi_did == FSAB_DID) && (fsabi_subdid == FSAB_SUBDID);
    assign beat_drop  = beat_match && (discard_q != '0);
    assign beat_keep  = beat_match && (discard_q == '0);
    assign pop        = request && (fifo_count != '0);
    assign offset_adv = {1'b0, offset_q} + 32'(DMA_BURST_BYTES);

    always_comb begin
        start_d = start_q;
        len_d   = len_q;
        if (reg_wr && reg_idx == DMA_REG_START) start_d = {spamo_data[30:6], 6'b0};
        if (reg_wr && reg_idx == DMA_REG_LEN)   len_d   = spamo_data[30:0];
    end

    always_comb begin
        offset_d = offset_q;
        if (issue) offset_d = (offset_adv > {1'b0, len_q}) ? '0 : offset_adv[30:0];
        if (ctrl_go) offset_d = '0;
    end

    // Beats already requested before a GO are counted off as they arrive.
    always_comb begin
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (issue) inflight_d = inflight_d + TRK_W'(DMA_BURST_BEATS);
        if (beat_keep && inflight_q != '0) inflight_d = inflight_d - 1'b1;
        if (beat_drop) discard_d = discard_d - 1'b1;
        if (ctrl_go) begin
            discard_d  = discard_d + inflight_d;
            inflight_d = '0;
        end
    end

    always_comb begin
        credits_d = credits_q;
        case ({issue, dmac__fsabo_credit})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: if (credits_q < CRED_W'(FSAB_INITIAL_CREDITS)) credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        case (reg_idx)
            DMA_REG_START:  spam_rdata = {1'b0, start_q};
            DMA_REG_LEN:    spam_rdata = {1'b0, len_q};
            DMA_REG_CTRL:   spam_rdata = {31'b0, running};
            DMA_REG_STATUS: spam_rdata = {1'b0, offset_q};
            default:        spam_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            start_q      <= '0;
            len_q        <= DEFAULT_LEN;
            offset_q     <= '0;
            credits_q    <= CRED_W'(FSAB_INITIAL_CREDITS);
            inflight_q   <= '0;
            discard_q    <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            spam_busy_q  <= 1'b0;
            spam_data_q  <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
        end else begin
            start_q      <= start_d;
            len_q        <= len_d;
            offset_q     <= offset_d;
            credits_q    <= credits_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            req_valid_q  <= issue;
            if (issue) req_addr_q <= start_q + offset_q;
            spam_busy_q  <= spam_hit;
            spam_data_q  <= (spam_hit && spamo_r_nw) ? spam_rdata : '0;
            data_ready_q <= pop;
            if (pop) data_q <= fifo_rdata;
        end
    end

    dma_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FSAB_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .flush_i     (ctrl_go),
        .push_i      (beat_keep),
        .push_data_i (fsabi_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count)
    );

    assign dmac__fsabo_valid  = req_valid_q;
    assign dmac__fsabo_mode   = FSAB_READ;
    assign dmac__fsabo_did    = req_valid_q ? FSAB_DID : '0;
    assign dmac__fsabo_subdid = req_valid_q ? FSAB_SUBDID : '0;
    assign dmac__fsabo_addr   = req_addr_q;
    assign dmac__fsabo_len    = req_valid_q ? DMA_BURST_BEATS : '0;
    assign dmac__fsabo_data   = '0;
    assign dmac__fsabo_mask   = '0;
    assign dmac__spami_busy_b = spam_busy_q;
    assign dmac__spami_data   = spam_data_q;
    assign data               = data_q;
    assign data_ready         = data_ready_q;
endmodule

// File: tb/tb_simple_dma_read_controller.sv
// Bench: register-map vector table, directed burst/credit/wrap/discard sequences, randomized model run.
module tb_simple_dma_read_controller;
    import simple_dma_read_controller_pkg::*;

    localparam logic [3:0]  P_FDID = 4'h3;
    localparam logic [3:0]  P_FSUB = 4'h5;
    localparam logic [3:0]  P_SDID = 4'h2;
    localparam logic [23:0] P_PFX  = 24'h001000;
    localparam logic [23:0] P_MASK = 24'hFFFFF0;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        fsabo_valid, fsabo_credit, fsabi_valid, spamo_valid, spamo_r_nw;
    logic        spami_busy_b, request, data_ready;
    logic [2:0]  fsabo_mode;
    logic [3:0]  fsabo_did, fsabo_subdid, fsabo_len, fsabi_did, fsabi_subdid, spamo_did;
    logic [30:0] fsabo_addr;
    logic [63:0] fsabo_data, fsabi_data, data;
    logic [7:0]  fsabo_mask;
    logic [23:0] spamo_addr;
    logic [31:0] spamo_data, spami_data;

    always #5 clk = ~clk;

    simple_dma_read_controller #(
        .FSAB_DID (P_FDID), .FSAB_SUBDID (P_FSUB), .SPAM_DID (P_SDID),
        .SPAM_ADDRPFX (P_PFX), .SPAM_ADDRMASK (P_MASK), .FIFO_DEPTH (16),
        .DEFAULT_LEN (31'h00000FFF), .FSAB_INITIAL_CREDITS (4)
    ) dut (
        .clk (clk), .rst_b (rst_b),
        .dmac__fsabo_valid (fsabo_valid), .dmac__fsabo_mode (fsabo_mode),
        .dmac__fsabo_did (fsabo_did), .dmac__fsabo_subdid (fsabo_subdid),
        .dmac__fsabo_addr (fsabo_addr), .dmac__fsabo_len (fsabo_len),
        .dmac__fsabo_data (fsabo_data), .dmac__fsabo_mask (fsabo_mask),
        .dmac__fsabo_credit (fsabo_credit),
        .fsabi_valid (fsabi_valid), .fsabi_did (fsabi_did),
        .fsabi_subdid (fsabi_subdid), .fsabi_data (fsabi_data),
        .spamo_valid (spamo_valid), .spamo_r_nw (spamo_r_nw), .spamo_did (spamo_did),
        .spamo_addr (spamo_addr), .spamo_data (spamo_data),
        .dmac__spami_busy_b (spami_busy_b), .dmac__spami_data (spami_data),
        .request (request), .data (data), .data_ready (data_ready)
    );

    typedef struct {
        logic        r_nw;
        logic [3:0]  did;
        logic [23:0] addr;
        logic [31:0] wd;
        logic        exp_busy;
        logic [31:0] exp_rd;
    } spam_vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [30:0] req_q[$];
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; every FSAB request seen is checked and logged.
    task automatic step();
        @(negedge clk);
        if (fsabo_valid) begin
            chk("req_back_to_back", 64'(prev_valid), 64'd0);
            chk("req_fields", {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_len, fsabo_mask, fsabo_addr[5:0]},
                {FSAB_READ, P_FDID, P_FSUB, 4'd8, 8'd0, 6'd0});
            chk("req_wdata", fsabo_data, 64'd0);
            req_q.push_back(fsabo_addr);
        end
        prev_valid = fsabo_valid;
    endtask

    task automatic do_reset();
        fsabo_credit = 0; fsabi_valid = 0; fsabi_did = 0; fsabi_subdid = 0; fsabi_data = 0;
        spamo_valid = 0; spamo_r_nw = 0; spamo_did = 0; spamo_addr = 0; spamo_data = 0; request = 0;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #3;
        chk("reset_ctl", {fsabo_valid, spami_busy_b, data_ready, fsabo_len, fsabo_did, fsabo_subdid}, 64'd0);
        chk("reset_addr", 64'(fsabo_addr), 64'd0);
        chk("reset_spam_data", 64'(spami_data), 64'd0);
        chk("reset_data", data, 64'd0);
        step(); step();
        rst_b = 1'b1;
        req_q.delete();
        prev_valid = 1'b0;
    endtask

    task automatic spam(input logic r_nw, input logic [3:0] did, input logic [23:0] addr,
                        input logic [31:0] wd, output logic busy, output logic [31:0] rd);
        spamo_valid = 1; spamo_r_nw = r_nw; spamo_did = did; spamo_addr = addr; spamo_data = wd;
        step();
        spamo_valid = 0; spamo_data = 0;
        busy = spami_busy_b;
        rd   = spami_data;
        step();
        chk("spam_busy_one_cycle", 64'(spami_busy_b), 64'd0);
    endtask

    task automatic reg_wr(input logic [3:0] idx, input logic [31:0] v);
        logic b; logic [31:0] r;
        spam(1'b0, P_SDID, P_PFX | {20'h0, idx}, v, b, r);
        chk("reg_wr_ack", {63'd0, b}, 64'd1);
    endtask

    task automatic reg_rd(input string name, input logic [3:0] idx, input logic [31:0] exp);
        logic b; logic [31:0] r;
        spam(1'b1, P_SDID, P_PFX | {20'h0, idx}, 32'd0, b, r);
        chk(name, {31'd0, b, r}, {31'd0, 1'b1, exp});
    endtask

    task automatic feed(input logic [63:0] base, input int n, input logic [3:0] did);
        for (int i = 0; i < n; i++) begin
            fsabi_valid = 1; fsabi_did = did; fsabi_subdid = P_FSUB; fsabi_data = base + 64'(i);
            step();
        end
        fsabi_valid = 0;
    endtask

    task automatic pop_check(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            request = 1;
            step();
            chk("pop_ready", 64'(data_ready), 64'd1);
            chk("pop_data", data, base + 64'(i));
        end
        request = 0;
    endtask

    task automatic empty_pop(input string name, input logic [63:0] held);
        request = 1;
        step();
        request = 0;
        chk(name, {data_ready, data[62:0]}, {1'b0, held[62:0]});
    endtask

    task automatic wait_reqs(input string name, input int n);
        int k = 0;
        while (req_q.size() < n && k < 40) begin
            step();
            k++;
        end
        chk(name, 64'(req_q.size()), 64'(n));
    endtask

    task automatic idle_count(input string name, input int n);
        repeat (20) step();
        chk(name, 64'(req_q.size()), 64'(n));
    endtask

    // Randomized traffic: addresses follow START + offset with 64-byte advance and wrap past LEN,
    // beats come back in request order, pops return words in arrival order.
    task automatic random_run();
        logic [30:0] start, exp_addr;
        logic [31:0] len, off;
        logic [30:0] bursts[$];
        logic [63:0] exp_words[$];
        logic [63:0] bd;
        int mc, owed, bi, rptr, fifo_words;
        logic cred_drv, beat_drv, exp_ready;
        do_reset();
        start = 31'($urandom & 32'h3FFF_FFC0);
        len   = 32'($urandom_range(0, 32'h2FF));
        reg_wr(DMA_REG_START, {1'b0, start});
        reg_wr(DMA_REG_LEN, len);
        reg_wr(DMA_REG_CTRL, 32'd2);
        mc = 4; owed = 0; bi = 0; rptr = 0; fifo_words = 0; off = 0; cred_drv = 0;
        for (int c = 0; c < 3000; c++) begin
            while (rptr < req_q.size()) begin
                exp_addr = start + off[30:0];
                chk("rand_addr", 64'(req_q[rptr]), 64'(exp_addr));
                chk("rand_credit_avail", 64'(mc > 0), 64'd1);
                mc--; owed++;
                bursts.push_back(req_q[rptr]);
                off = off + 32'd64;
                if (off > len) off = 0;
                rptr++;
            end
            if (cred_drv) mc++;
            cred_drv = (owed > 0) && ($urandom_range(0, 3) == 0);
            if (cred_drv) owed--;
            fsabo_credit = cred_drv;
            beat_drv = 0;
            fsabi_valid = 0;
            if (bursts.size() > 0 && $urandom_range(0, 1) == 1) begin
                bd = {1'b0, bursts[0], 29'd0, 3'(bi)};
                fsabi_valid = 1; fsabi_did = P_FDID; fsabi_subdid = P_FSUB; fsabi_data = bd;
                beat_drv = 1;
                bi++;
                if (bi == 8) begin bi = 0; void'(bursts.pop_front()); end
            end else if ($urandom_range(0, 7) == 0) begin
                fsabi_valid = 1;
                fsabi_did = ($urandom_range(0, 1) == 1) ? (P_FDID ^ 4'h1) : P_FDID;
                fsabi_subdid = (fsabi_did == P_FDID) ? (P_FSUB ^ 4'h2) : P_FSUB;
                fsabi_data = {$urandom, $urandom};
            end
            request = ($urandom_range(0, 1) == 1);
            step();
            exp_ready = request && (fifo_words > 0);
            chk("rand_ready", 64'(data_ready), 64'(exp_ready));
            if (exp_ready) begin
                chk("rand_data", data, exp_words.pop_front());
                fifo_words--;
            end
            if (beat_drv) begin
                exp_words.push_back(bd);
                fifo_words++;
            end
        end
        fsabo_credit = 0; fsabi_valid = 0; request = 0;
        chk("rand_progress", 64'(req_q.size() > 8), 64'd1);
    endtask

    initial begin
        spam_vec_t tbl [14];
        logic b; logic [31:0] r;
        tbl[0]  = '{1'b1, P_SDID, 24'h001001, 32'h0,         1'b1, 32'h00000FFF};
        tbl[1]  = '{1'b1, P_SDID, 24'h001000, 32'h0,         1'b1, 32'h0};
        tbl[2]  = '{1'b1, P_SDID, 24'h001002, 32'h0,         1'b1, 32'h0};
        tbl[3]  = '{1'b1, P_SDID, 24'h001003, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{1'b0, P_SDID, 24'h001000, 32'hFFFFFFFF,  1'b1, 32'h0};
        tbl[5]  = '{1'b1, P_SDID, 24'h001000, 32'h0,         1'b1, 32'h7FFFFFC0};
        tbl[6]  = '{1'b0, P_SDID, 24'h001001, 32'h80001234,  1'b1, 32'h0};
        tbl[7]  = '{1'b1, P_SDID, 24'h001001, 32'h0,         1'b1, 32'h00001234};
        tbl[8]  = '{1'b1, P_SDID, 24'h001009, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b1, 4'h7,   24'h001001, 32'h0,         1'b0, 32'h0};
        tbl[10] = '{1'b1, P_SDID, 24'h001011, 32'h0,         1'b0, 32'h0};
        tbl[11] = '{1'b0, P_SDID, 24'h001007, 32'h12345678,  1'b1, 32'h0};
        tbl[12] = '{1'b0, P_SDID, 24'h001000, 32'h0,         1'b1, 32'h0};
        tbl[13] = '{1'b0, P_SDID, 24'h001001, 32'h00000FFF,  1'b1, 32'h0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            spam(tbl[i].r_nw, tbl[i].did, tbl[i].addr, tbl[i].wd, b, r);
            chk($sformatf("tbl%0d_busy", i), 64'(b), 64'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_rdata", i), 64'(r), 64'(tbl[i].exp_rd));
        end

        // Two bursts fill the 16-word reservation, then draining opens a third.
        reg_wr(DMA_REG_CTRL, 32'd2);
        wait_reqs("first_two_bursts", 2);
        chk("burst0_addr", 64'(req_q[0]), 64'h0);
        chk("burst1_addr", 64'(req_q[1]), 64'h40);
        idle_count("stall_at_depth", 2);
        reg_rd("status_offset", DMA_REG_STATUS, 32'h80);
        feed(64'd0, 8, P_FDID);
        pop_check(64'd0, 8);
        empty_pop("empty_pop_ignored", 64'd7);
        wait_reqs("third_burst", 3);
        chk("burst2_addr", 64'(req_q[2]), 64'h80);
        feed(64'h100, 8, P_FDID);
        pop_check(64'h100, 8);
        wait_reqs("fourth_burst", 4);
        chk("burst3_addr", 64'(req_q[3]), 64'hC0);
        feed(64'h200, 16, P_FDID);
        pop_check(64'h200, 16);
        idle_count("credit_limit", 4);
        fsabo_credit = 1;
        step();
        fsabo_credit = 0;
        wait_reqs("one_credit_one_req", 5);
        chk("burst4_addr", 64'(req_q[4]), 64'h100);
        idle_count("credit_exhausted_again", 5);

        // LEN wrap, then GO with beats in flight and partly buffered.
        do_reset();
        reg_wr(DMA_REG_LEN, 32'h7F);
        reg_wr(DMA_REG_CTRL, 32'd2);
        wait_reqs("wrap_two", 2);
        chk("wrap_addr0", 64'(req_q[0]), 64'h0);
        chk("wrap_addr1", 64'(req_q[1]), 64'h40);
        feed(64'h300, 8, P_FDID);
        pop_check(64'h300, 8);
        wait_reqs("wrap_three", 3);
        chk("wrap_addr2", 64'(req_q[2]), 64'h0);
        feed(64'h400, 4, P_FDID);
        reg_wr(DMA_REG_START, 32'h1000);
        reg_wr(DMA_REG_CTRL, 32'd2);
        wait_reqs("go_restart", 4);
        chk("go_addr", 64'(req_q[3]), 64'h1000);
        empty_pop("go_flushed", 64'h307);
        feed(64'hBAD0, 8, P_FDID ^ 4'h1);
        feed(64'h500, 12, P_FDID);
        empty_pop("stale_beats_dropped", 64'h307);
        feed(64'h600, 8, P_FDID);
        pop_check(64'h600, 8);
        empty_pop("after_new_burst", 64'h607);
        reg_rd("ctrl_running", DMA_REG_CTRL, 32'h1);
        reg_rd("status_after_go", DMA_REG_STATUS, 32'h40);
        reg_wr(DMA_REG_CTRL, 32'd1);
        reg_rd("ctrl_stopped", DMA_REG_CTRL, 32'h0);
        fsabo_credit = 1;
        step();
        fsabo_credit = 0;
        idle_count("stop_no_issue", 4);

        random_run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1);
    end
endmodule
